// File: rtl/led_sched_pkg.sv
// led_sched_pkg: state encoding, default sizing and a small index helper
// shared by led_scheduler and its bench.
package led_sched_pkg;

  localparam int NREQ_DEFAULT       = 4;
  localparam int PAT_W_DEFAULT      = 5;
  localparam int TICK_WIDTH_DEFAULT = 20;
  localparam int HOLD_TICKS_DEFAULT = 4;

  // Hold counter width covers the full 1..255 HOLD_TICKS range.
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    HANDOFF = 2'd2
  } sched_state_e;

  // Next requester index, wrapping modulo n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running TICK_WIDTH-bit counter; TICK is a registered
// one-cycle pulse in the cycle the count has just wrapped to zero.
module tick_prescaler #(
  parameter int TICK_WIDTH = 20
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  logic [TICK_WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      TICK    <= 1'b0;
    end else begin
      count_q <= count_q + TICK_WIDTH'(1);
      TICK    <= &count_q;
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// led_scheduler: round-robin ownership of a shared LED bank with tick-based
// minimum hold and preemption. Build option: LED_SCHEDULER_HEARTBEAT_EN.
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int NREQ       = NREQ_DEFAULT,
  parameter int PAT_W      = PAT_W_DEFAULT,
  parameter int TICK_WIDTH = TICK_WIDTH_DEFAULT,
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*PAT_W-1:0] PAT,
  output logic [NREQ-1:0]       GNT,
  output logic [PAT_W-1:0]      LED,
  output logic                  TICK,
  output logic                  BUSY
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  sched_state_e      state_q, state_d;
  idx_t              owner_q, owner_d;
  idx_t              ptr_q, ptr_d;
  idx_t              owner_inc, scan_base, pick;
  logic              pick_found;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   pick_oh, owner_oh, others;
  logic [PAT_W-1:0]  led_q, led_d;
  logic [PAT_W-1:0]  owner_pat, idle_led;
  logic [PAT_W-1:0]  pat_arr [NREQ];
  logic              busy_q;
  logic              hold_full, owner_release, preempt;
  logic              tick;

  tick_prescaler #(
    .TICK_WIDTH (TICK_WIDTH)
  ) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick)
  );

  assign TICK = tick;
  assign GNT  = gnt_q;
  assign LED  = led_q;
  assign BUSY = busy_q;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      pat_arr[k] = PAT[k*PAT_W +: PAT_W];
    end
  end

  assign owner_pat = pat_arr[owner_q];
  assign owner_inc = idx_t'(wrap_inc(int'(owner_q), NREQ));

`ifdef LED_SCHEDULER_HEARTBEAT_EN
  logic hb_q;
  logic hb_d;

  assign hb_d = hb_q ^ tick;

  always_ff @(posedge CLK) begin
    if (RST) hb_q <= 1'b0;
    else     hb_q <= hb_d;
  end

  always_comb begin
    idle_led            = '0;
    idle_led[PAT_W-1]   = hb_d;
  end
`else
  assign idle_led = '0;
`endif

  // Round-robin scan: first set request at or above the base, then wrap below it.
  // HANDOFF scans from owner+1 so the pointer update and the new grant share one edge.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    scan_base  = (state_q == HANDOFF) ? owner_inc : ptr_q;
    pick       = scan_base;
    pick_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && REQ[k] && (k >= int'(scan_base))) begin
        pick       = idx_t'(k);
        pick_found = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && REQ[k] && (k < int'(scan_base))) begin
        pick       = idx_t'(k);
        pick_found = 1'b1;
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    others            = REQ & ~owner_oh;
    owner_release     = !REQ[owner_q];
    hold_full         = (hold_q == HOLD_W'(HOLD_TICKS));
    preempt           = hold_full && (|others);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          owner_d = pick;
          hold_d  = '0;
          gnt_d   = pick_oh;
        end
      end

      OWNED: begin
        if (tick && !hold_full) hold_d = hold_q + HOLD_W'(1);
        // Release is checked first, so a release coinciding with a tick is a release.
        if (owner_release || preempt) begin
          state_d = HANDOFF;
          gnt_d   = '0;
        end
      end

      HANDOFF: begin
        ptr_d = owner_inc;
        if (pick_found) begin
          state_d = OWNED;
          owner_d = pick;
          hold_d  = '0;
          gnt_d   = pick_oh;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // The owner's pattern is shown only while ownership continues across the edge;
    // grant and handoff edges blank the bank for one cycle.
    if ((state_q == OWNED) && (state_d == OWNED)) led_d = owner_pat;
    else if (state_d == IDLE)                     led_d = idle_led;
    else                                          led_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      busy_q  <= (state_d == OWNED);
    end
  end

endmodule

// File: doc/led_scheduler.md
LED_SCHEDULER -- requirements
Module: led_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters sharing the LED bank.
REQ-002 SHALL have parameter PAT_W, default 5, meaning LED bank width.
REQ-003 SHALL have parameter TICK_WIDTH, default 20, meaning prescaler width; one tick every 2^TICK_WIDTH clocks.
REQ-004 SHALL have parameter HOLD_TICKS, default 4, meaning minimum owner ticks before preemption (range 1..255).
REQ-005 SHALL have port CLK  in  1  system clock (PLL global clock).
REQ-006 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port REQ  in  NREQ  per-requester level request.
REQ-008 SHALL have port PAT  in  NREQ*PAT_W  packed requester patterns; requester i occupies bits [i*PAT_W +: PAT_W].
REQ-009 SHALL have port GNT  out  NREQ  one-hot grant, at most one bit set.
REQ-010 SHALL have port LED  out  PAT_W  registered LED drive.
REQ-011 SHALL have port TICK  out  1  one-cycle prescaler pulse.
REQ-012 SHALL have port BUSY  out  1  high when any requester owns the bank.

Function
REQ-013 SHALL run a free-running TICK_WIDTH-bit prescaler and assert TICK for exactly the one cycle in which the count wraps from all-ones to zero.
REQ-014 SHALL implement states IDLE, OWNED and HANDOFF.
REQ-015 In IDLE, on any REQ bit set, SHALL grant the first requester at or after the round-robin pointer, scanning upward modulo NREQ, and enter OWNED next cycle.
REQ-016 In OWNED, SHALL count ticks in a hold counter cleared on grant and saturating at HOLD_TICKS.
REQ-017 In OWNED, if the owner deasserts REQ, SHALL enter HANDOFF next cycle regardless of hold count.
REQ-018 In OWNED, if hold count equals HOLD_TICKS and any other REQ bit is set, SHALL preempt and enter HANDOFF.
REQ-019 HANDOFF SHALL last exactly one cycle with GNT=0 and LED=0, set the pointer to owner+1 mod NREQ, then go to OWNED (the next requester chosen per REQ-015) if any REQ is set, else IDLE.
REQ-020 A sole requester holding REQ SHALL keep ownership indefinitely; no preemption without a competitor.
REQ-021 GNT and BUSY SHALL be registered and change on the clock edge entering the new state.
REQ-022 LED SHALL equal the owner's PAT slice sampled one cycle earlier (1-cycle latency); PAT changes during ownership SHALL propagate with that latency.
REQ-023 Owner release and tick in the same cycle SHALL be treated as release (REQ-017 wins).
REQ-024 Simultaneous requests SHALL be resolved only by the pointer; lower index has no fixed priority.
REQ-025 Requests from non-owners SHALL have no effect on LED or GNT until a handoff.

Reset
REQ-026 While RST is high at a CLK edge: state=IDLE, GNT=0, LED=0, BUSY=0, TICK=0, prescaler=0, hold counter=0, pointer=0.
REQ-027 Reset asserted mid-ownership SHALL drop the grant on the same edge with no HANDOFF cycle.

Configuration
REQ-028 Macro LED_SCHEDULER_HEARTBEAT_EN defined: in IDLE, LED[PAT_W-1] SHALL toggle on every TICK, other LED bits 0; toggle register reset to 0.
REQ-029 Macro LED_SCHEDULER_HEARTBEAT_EN undefined: LED SHALL be all-zero in IDLE and no toggle register SHALL exist.

Structure
REQ-030 Package led_sched_pkg SHALL hold the state enum (IDLE, OWNED, HANDOFF) and default constants for NREQ and PAT_W.
REQ-031 The prescaler SHALL be a separate sub-module tick_prescaler (ports CLK, RST, TICK; parameter TICK_WIDTH).

Verification (bench parameters: TICK_WIDTH=4, HOLD_TICKS=2, NREQ=4, PAT_W=5)
REQ-032 Reset release, no requests -> TICK at cycle 16, 32, 48; GNT=0, LED=0 (heartbeat build: LED=5'b10000 after first tick, 5'b00000 after second).
REQ-033 REQ=4'b0010, PAT1=5'b00101 -> GNT=4'b0010 one cycle later, LED=5'b00101 the following cycle; held 100 cycles -> no change.
REQ-034 REQ0 and REQ2 asserted together from reset -> GNT=0001; after 2 ticks: one HANDOFF cycle (GNT=0, LED=0), then GNT=0100.
REQ-035 Owner REQ1 dropped on a TICK cycle with hold=1 -> HANDOFF next cycle, then IDLE; pointer=2, so later REQ=4'b1101 grants requester 2.
REQ-036 RST pulsed for one cycle while GNT=0100 -> GNT=0, LED=0, BUSY=0 on that edge; prescaler restarts, first TICK 16 cycles after reset release.
